// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, frame constants and
// the odd-parity check used when the stop bit is sampled.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic ODD_PARITY = 1'b1;

    // A frame is good when the data byte plus its parity bit has an odd
    // number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
        return ((^{data, par}) == ODD_PARITY);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head word and valid flag are registered: they are computed from the
// next-state pointers so the head is correct on the edge that pushes or pops.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             do_rd_s;
    logic             do_wr_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;
    logic             valid_nxt_s;

    // Decide which operations take effect and derive next pointers/count/head.
    always_comb begin
        do_rd_s      = rd && (count_r != {CW{1'b0}});
        // A full FIFO still accepts a write when a read frees a slot in the same cycle.
        do_wr_s      = wr && ((count_r != FULL) || do_rd_s);
        drop         = wr && !do_wr_s;
        rd_ptr_nxt_s = do_rd_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        wr_ptr_nxt_s = do_wr_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        valid_nxt_s = (count_nxt_s != {CW{1'b0}});
        if (!valid_nxt_s) begin
            head_nxt_s = {WIDTH{1'b0}};
        end else if (do_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; written only when a push is accepted.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= valid_nxt_s;
        end
    end

    assign rd_data  = head_r;
    assign rd_valid = valid_r;
    assign count    = count_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: pin synchronisation, glitch filtering on the ce strobe,
// falling-edge frame decoding with parity/stop checks and an inter-edge
// timeout, feeding a first-word-fall-through byte FIFO with sticky errors.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2000,
    parameter int DROP_BAD   = 1
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          ce,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    input  logic                          rd,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          overflow
);

    localparam int            TW       = $clog2(TIMEOUT);
    localparam int            FW       = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic             clk_filt_r, data_filt_r;
    logic [FW-1:0]    clk_cnt_r, data_cnt_r;
    ps2_state_e       state_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             par_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic             err_parity_r, err_frame_r, overflow_r;

    logic             fall_s;
    logic             tmo_s;
    logic             stop_s;
    logic             par_ok_s;
    logic             push_s;
    logic             perr_s;
    logic             ferr_s;
    logic             drop_s;

    // Two-flop synchronisers; preset high so a reset looks like an idle bus.
    always_ff @(posedge clk) begin
        if (res) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clock;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Clock-line glitch filter: level follows only after FILTER_LEN equal ce samples.
    always_ff @(posedge clk) begin
        if (res) begin
            clk_filt_r <= 1'b1;
            clk_cnt_r  <= {FW{1'b0}};
        end else if (ce) begin
            if (clk_sync_r == clk_filt_r) begin
                clk_cnt_r <= {FW{1'b0}};
            end else if (clk_cnt_r == FLT_LAST) begin
                clk_filt_r <= clk_sync_r;
                clk_cnt_r  <= {FW{1'b0}};
            end else begin
                clk_cnt_r <= clk_cnt_r + FW'(1);
            end
        end
    end

    // Data-line glitch filter, same rule as the clock line.
    always_ff @(posedge clk) begin
        if (res) begin
            data_filt_r <= 1'b1;
            data_cnt_r  <= {FW{1'b0}};
        end else if (ce) begin
            if (data_sync_r == data_filt_r) begin
                data_cnt_r <= {FW{1'b0}};
            end else if (data_cnt_r == FLT_LAST) begin
                data_filt_r <= data_sync_r;
                data_cnt_r  <= {FW{1'b0}};
            end else begin
                data_cnt_r <= data_cnt_r + FW'(1);
            end
        end
    end

    // Frame events: the falling edge is the ce cycle where the filtered clock flips 1 -> 0.
    always_comb begin
        fall_s   = ce && clk_filt_r && !clk_sync_r && (clk_cnt_r == FLT_LAST);
        tmo_s    = ce && !fall_s && (state_r != IDLE) && (tmo_cnt_r == TMO_LAST);
        stop_s   = fall_s && (state_r == STOP);
        par_ok_s = odd_parity_ok(shift_r, par_r);
        push_s   = stop_s && data_filt_r && (par_ok_s || (DROP_BAD == 0));
        perr_s   = stop_s && data_filt_r && !par_ok_s;
        ferr_s   = (stop_s && !data_filt_r) || tmo_s;
    end

    // Frame FSM with its bit index, shift register, parity capture and timeout counter.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r   <= IDLE;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            tmo_cnt_r <= {TW{1'b0}};
        end else if (ce) begin
            if (fall_s) begin
                tmo_cnt_r <= {TW{1'b0}};
                case (state_r)
                    IDLE: begin
                        if (!data_filt_r) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_r <= {data_filt_r, shift_r[7:1]};
                        if (bit_idx_r == BIT_LAST) begin
                            state_r <= PARITY;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                    PARITY: begin
                        par_r   <= data_filt_r;
                        state_r <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (tmo_s) begin
                state_r   <= IDLE;
                tmo_cnt_r <= {TW{1'b0}};
            end else if (state_r != IDLE) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= {TW{1'b0}};
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (res) begin
            err_parity_r <= 1'b0;
            err_frame_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            err_parity_r <= perr_s | (err_parity_r & ~err_clr);
            err_frame_r  <= ferr_s | (err_frame_r & ~err_clr);
            overflow_r   <= drop_s | (overflow_r & ~err_clr);
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .res      (res),
        .wr       (push_s),
        .wr_data  (shift_r),
        .rd       (rd),
        .rd_data  (rx_data),
        .rd_valid (rx_valid),
        .count    (rx_count),
        .drop     (drop_s)
    );

    assign err_parity = err_parity_r;
    assign err_frame  = err_frame_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a table of frames with expected FIFO and
// flag state, followed by hand-written multi-cycle corner-case sequences.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int FLT   = 4;
    localparam int TMO   = 64;
    localparam int H     = 10;   // ce ticks per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       res, ce, ps2_clock, ps2_data, rd, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       err_parity, err_frame, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_before_stop;
    int cnt_after_stop;

    typedef struct {
        logic       clr;
        int         pops;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [13];

    ps2_rx_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FLT),
        .TIMEOUT    (TMO),
        .DROP_BAD   (1)
    ) dut (
        .clk        (clk),
        .res        (res),
        .ce         (ce),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_count   (rx_count),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ce_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ce = 1'b1;
            @(negedge clk) ce = 1'b0;
            @(negedge clk);
        end
    endtask

    // Change the pins and give the synchroniser two clocks before the next ce.
    task automatic set_pins(input logic c, input logic d);
        ps2_clock = c;
        ps2_data  = d;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One PS/2 bit; the falling edge is seen on the FLT-th ce of the low half.
    task automatic send_bit(input logic b, input logic rd_at_edge);
        set_pins(1'b1, b);
        ce_ticks(H);
        set_pins(1'b0, b);
        ce_ticks(FLT - 1);
        cnt_before_stop = int'(rx_count);
        @(negedge clk) begin ce = 1'b1; rd = rd_at_edge; end
        @(negedge clk) begin ce = 1'b0; rd = 1'b0; end
        @(negedge clk);
        cnt_after_stop = int'(rx_count);
        ce_ticks(H - FLT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic rd_at_stop);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(stop, rd_at_stop);
        set_pins(1'b1, 1'b1);
        ce_ticks(H);
    endtask

    task automatic pulse_rd();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, rx_valid, 1'b1);
        check(name, rx_data, exp);
        pulse_rd();
    endtask

    task automatic check_flags(input string name, input logic p, input logic f, input logic o);
        check({name, "_err_parity"}, err_parity, p);
        check({name, "_err_frame"},  err_frame,  f);
        check({name, "_overflow"},   overflow,   o);
    endtask

    initial begin
        logic [7:0] d;
        // clr pops data par stop | count head perr ferr ovf
        vecs[0] = '{1'b0, 0, 8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1, 8'h1C, 1'b1, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 0, 8'hF0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 0, 8'h5A, 1'b1, 1'b1, 1, 8'h5A, 1'b0, 1'b0, 1'b0};
        for (int i = 4; i < 13; i++) begin
            d = 8'(i - 3);
            vecs[i] = '{1'b0, (i == 4) ? 1 : 0, d, ~^d, 1'b1,
                        (i - 3 > 8) ? 8 : i - 3, 8'h01, 1'b0, 1'b0, (i == 12)};
        end

        res = 1'b1; ce = 1'b0; ps2_clock = 1'b1; ps2_data = 1'b1; rd = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_count", rx_count, 4'd0);
        check("reset_rx_data",  rx_data,  8'h00);
        check_flags("reset", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].clr) pulse_clr();
            for (int k = 0; k < vecs[i].pops; k++) pulse_rd();
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b0);
            check($sformatf("vec%0d_count", i), rx_count, 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_valid", i), rx_valid, (vecs[i].exp_count > 0));
            if (vecs[i].exp_count > 0)
                check($sformatf("vec%0d_head", i), rx_data, vecs[i].exp_head);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_ovf);
            if (i == 0) begin
                check("latency_before_edge", cnt_before_stop, 0);
                check("latency_at_edge", cnt_after_stop, 1);
            end
        end

        // Overflowed FIFO drains oldest-first; the ninth byte was dropped.
        for (int k = 1; k <= 8; k++) pop_check($sformatf("drain_%0d", k), 8'(k));
        check("drained_valid", rx_valid, 1'b0);
        check("drained_count", rx_count, 4'd0);
        pulse_rd();
        check("rd_empty_count", rx_count, 4'd0);

        // Push and rd together while empty: the push wins.
        pulse_clr();
        send_frame(8'h33, 1'b1, 1'b1, 1'b1);
        check("push_rd_empty_count", rx_count, 4'd1);
        check("push_rd_empty_head", rx_data, 8'h33);
        pulse_rd();

        // Push and rd together while full: count holds, no overflow.
        for (int k = 0; k < 8; k++) begin
            d = 8'h10 + 8'(k);
            send_frame(d, ~^d, 1'b1, 1'b0);
        end
        check("full_count", rx_count, 4'd8);
        send_frame(8'h18, 1'b1, 1'b1, 1'b1);
        check("simul_before", cnt_before_stop, 8);
        check("simul_after", cnt_after_stop, 8);
        check("simul_count", rx_count, 4'd8);
        check("simul_overflow", overflow, 1'b0);
        for (int k = 1; k <= 8; k++) pop_check($sformatf("simul_pop_%0d", k), 8'h10 + 8'(k));

        // Two-sample low glitch on the clock while idle is filtered out.
        set_pins(1'b1, 1'b0); ce_ticks(H);
        set_pins(1'b0, 1'b0); ce_ticks(2);
        set_pins(1'b1, 1'b0); ce_ticks(H);
        set_pins(1'b1, 1'b1); ce_ticks(H);
        check("glitch_count", rx_count, 4'd0);
        check_flags("glitch", 1'b0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b1, 1'b0);
        check("after_glitch_count", rx_count, 4'd1);
        check("after_glitch_head", rx_data, 8'h6B);
        check_flags("after_glitch", 1'b0, 1'b0, 1'b0);
        pulse_rd();

        // Start plus five data bits, then the clock stalls high past the timeout.
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) send_bit(k[0], 1'b0);
        set_pins(1'b1, 1'b1);
        ce_ticks(TMO + 16);
        check("timeout_count", rx_count, 4'd0);
        check_flags("timeout", 1'b0, 1'b1, 1'b0);
        pulse_clr();
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("after_timeout_count", rx_count, 4'd1);
        check("after_timeout_head", rx_data, 8'h29);
        check_flags("after_timeout", 1'b0, 1'b0, 1'b0);

        // Reset mid-frame empties the FIFO and abandons the frame silently.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk) res = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("midreset_count", rx_count, 4'd0);
        check("midreset_valid", rx_valid, 1'b0);
        check("midreset_data", rx_data, 8'h00);
        check_flags("midreset", 1'b0, 1'b0, 1'b0);
        set_pins(1'b1, 1'b1); ce_ticks(H);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check("after_reset_count", rx_count, 4'd1);
        check("after_reset_head", rx_data, 8'hA5);
        check_flags("after_reset", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 keyboard/mouse receiver.
- Adds to the current receiver:
  - input synchronisation and a glitch filter;
  - falling-edge sampling with full frame checking (start, odd parity, stop);
  - a configurable inter-edge timeout;
  - a first-word-fall-through receive FIFO with occupancy count and sticky error flags.
- Sits between the PS/2 connector pins and the CPU I/O port logic. The CPU pops bytes with `rd` instead of a single done/ack pair.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64.
- FILTER_LEN, 4, consecutive equal `ce` samples required before the filtered PS/2 clock/data level changes.
- TIMEOUT, 2000, `ce` ticks allowed between falling edges inside a frame before the frame is aborted.
- DROP_BAD, 1, 1 = frames with a parity error are discarded; 0 = they are pushed anyway.

Ports:
- clk  in  1  system clock (50 MHz).
- res  in  1  synchronous reset, active-high.
- ce  in  1  sampling strobe, one `clk` wide (nominally 1 MHz).
- ps2_clock  in  1  PS/2 CLOCK pin, asynchronous.
- ps2_data  in  1  PS/2 DATA pin, asynchronous.
- rd  in  1  pop strobe, one `clk` wide.
- err_clr  in  1  clears all sticky error flags.
- rx_data  out  8  FIFO head byte; valid while `rx_valid` = 1.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- err_parity  out  1  sticky: a frame had bad parity.
- err_frame  out  1  sticky: bad stop bit or timeout abort.
- overflow  out  1  sticky: a good frame arrived while the FIFO was full.

Behaviour:
- Reset:
  - All outputs return to 0; FIFO is empty.
  - FSM goes to IDLE; timeout counter is 0.
  - Filter registers preset to 1 (bus idle high).
  - Reset mid-frame aborts the frame with no flag set.
- Input conditioning:
  - Two-flop synchroniser on `clk` for both pins.
  - Sampling happens only on `ce` cycles.
  - A filtered level changes only after FILTER_LEN consecutive `ce` samples of the new value.
  - A falling edge is filtered clock 1 -> 0, detected on a `ce` cycle.
- FSM (advances only on `ce` with a falling edge, except for timeout):
  - IDLE: on a falling edge with filtered data = 0, go to DATA with bit index 0. With data = 1, stay in IDLE with no error.
  - DATA: shift data in LSB first. After bit 7, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: parity is good when XOR of {byte, parity bit} = 1 (odd parity). Then:
    - stop bit = 0: set `err_frame`, push nothing.
    - stop = 1 and parity good: push.
    - stop = 1 and parity bad: set `err_parity`; push only if DROP_BAD = 0.
    - Always return to IDLE.
- Timeout:
  - Outside IDLE, the counter increments on each `ce` and clears on each falling edge.
  - Reaching TIMEOUT-1 forces IDLE and sets `err_frame`.
  - Counter width is $clog2(TIMEOUT).
- FIFO:
  - First-word fall-through: `rx_data` shows the oldest byte.
  - Push and pop complete in the same `clk`.
  - Latency: a pushed byte appears on `rx_data`/`rx_valid` on the `clk` edge after the `ce` cycle in which the stop bit was sampled.
  - `rd` while empty is ignored.
  - Push while full: the byte is dropped and `overflow` is set.
  - Push and `rd` in the same cycle while full: both take effect, count unchanged, no overflow.
  - Push and `rd` in the same cycle while empty: the push happens and `rd` is ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Sticky flags:
  - Cleared by `err_clr`.
  - A set and a clear in the same cycle: set wins.

Decomposition:
- Shared package `ps2_pkg` holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - frame constants (DATA_BITS = 8, odd parity);
  - a function computing odd parity.
- One natural sub-module: `sync_fifo` (parametrised width/depth, first-word fall-through, count output), reusable by the UART.

Test Plan:
- Valid frame: send 0x1C with parity 0 and stop 1 at a 12.5 kHz PS/2 clock -> `rx_valid` = 1, `rx_data` = 0x1C, `rx_count` = 1, all flags 0. Pulse `rd` -> `rx_valid` = 0.
- Bad parity: send 0x1C with parity 1, DROP_BAD = 1 -> `err_parity` = 1, `rx_count` = 0. Pulse `err_clr` -> `err_parity` = 0.
- Framing: send 0xF0 with stop bit 0 -> `err_frame` = 1, FIFO empty. Next valid 0x5A frame is received correctly.
- Overflow: send 9 valid bytes 0x01..0x09 with no reads -> `rx_count` = 8, `overflow` = 1. Pops return 0x01..0x08 in order.
- Timeout: send start + 5 data bits, then hold the clock high for more than TIMEOUT ticks -> `err_frame` = 1, FSM in IDLE. A following 0x29 frame is received intact.
- Glitch/simultaneity:
  - A 2-`ce` low pulse on `ps2_clock` while idle -> no state change.
  - Push and `rd` in the same `clk` while full -> count stays 8, `overflow` stays 0.
